// File: rtl/dht_pkg.sv
// Shared types and helpers for the DHT poll scheduler.
package dht_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BUSY,
      CHECK,
      FAIL,
      GAP
   } state_t;

   // Byte positions inside the 40-bit DHT frame
   localparam int unsigned HUMI_INT_LSB = 32;
   localparam int unsigned HUMI_DEC_LSB = 24;
   localparam int unsigned TEMP_INT_LSB = 16;
   localparam int unsigned TEMP_DEC_LSB = 8;
   localparam int unsigned CSUM_LSB     = 0;

   // 8-bit wrapping sum of the four payload bytes
   function automatic logic [7:0] frame_sum(input logic [39:0] frame);
      logic [7:0] sum;
      sum = frame[HUMI_INT_LSB +: 8] + frame[HUMI_DEC_LSB +: 8]
          + frame[TEMP_INT_LSB +: 8] + frame[TEMP_DEC_LSB +: 8];
      return sum;
   endfunction

endpackage

// File: rtl/dht_checksum.sv
// Splits a DHT frame into its payload bytes and flags a matching checksum.
module dht_checksum
   import dht_pkg::*;
(
   input  logic [39:0] frame,
   output logic        ok,
   output logic [7:0]  humi_int,
   output logic [7:0]  humi_dec,
   output logic [7:0]  temp_int,
   output logic [7:0]  temp_dec
);

   assign humi_int = frame[HUMI_INT_LSB +: 8];
   assign humi_dec = frame[HUMI_DEC_LSB +: 8];
   assign temp_int = frame[TEMP_INT_LSB +: 8];
   assign temp_dec = frame[TEMP_DEC_LSB +: 8];
   assign ok       = (frame_sum(frame) == frame[CSUM_LSB +: 8]);

endmodule

// File: rtl/dht_poll_scheduler.sv
// Periodic / on-demand read scheduler for a DHT single-wire controller:
// launches reads, supervises them, validates checksums, retries failures
// after a guard gap and publishes the last good measurement.
module dht_poll_scheduler
   import dht_pkg::*;
#(
   parameter int unsigned DHT_OUT         = 40,
   parameter int unsigned POLL_MS         = 11000,
   parameter int unsigned RETRY_GAP_MS    = 1100,
   parameter int unsigned BUSY_TIMEOUT_MS = 50,
   parameter int unsigned MAX_RETRY       = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_1ms,
   input  logic               i_enable,
   input  logic               i_force,
   output logic               dht_start,
   input  logic [DHT_OUT-1:0] dht_data,
   input  logic               dht_done,
   input  logic               dht_tout,
   output logic [7:0]         o_humi_int,
   output logic [7:0]         o_humi_dec,
   output logic [7:0]         o_temp_int,
   output logic [7:0]         o_temp_dec,
   output logic               o_valid,
   output logic               o_update,
   output logic               o_err,
   output logic [7:0]         o_fail_cnt,
   output logic               o_busy
);

   localparam int unsigned PW = (POLL_MS > 1)         ? $clog2(POLL_MS)         : 1;
   localparam int unsigned TW = (BUSY_TIMEOUT_MS > 1) ? $clog2(BUSY_TIMEOUT_MS) : 1;
   localparam int unsigned GW = (RETRY_GAP_MS > 1)    ? $clog2(RETRY_GAP_MS)    : 1;
   localparam int unsigned RW = (MAX_RETRY > 0)       ? $clog2(MAX_RETRY + 1)   : 1;

   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MS - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT_MS - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP_MS - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   state_t        state, state_next;
   logic [PW-1:0] poll_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [GW-1:0] gap_cnt;
   logic [RW-1:0] retry_cnt;
   logic          force_pend;
   logic          first_pend;
   logic          enter_start;

   logic          chk_ok;
   logic [7:0]    chk_humi_int, chk_humi_dec, chk_temp_int, chk_temp_dec;

   dht_checksum u_checksum (
      .frame    (dht_data[39:0]),
      .ok       (chk_ok),
      .humi_int (chk_humi_int),
      .humi_dec (chk_humi_dec),
      .temp_int (chk_temp_int),
      .temp_dec (chk_temp_dec)
   );

   assign dht_start = (state == START);
   assign o_busy    = (state != IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode; done beats controller timeout beats hang timer
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:  if (i_enable && (first_pend || force_pend || poll_cnt == POLL_LAST))
                   state_next = START;
         START: state_next = BUSY;
         BUSY: begin
            if (dht_done)                            state_next = CHECK;
            else if (dht_tout)                       state_next = FAIL;
            else if (tick_1ms && tmo_cnt == TMO_LAST) state_next = FAIL;
         end
         CHECK: state_next = chk_ok ? IDLE : FAIL;
         FAIL:  state_next = (retry_cnt == RETRY_MAX) ? IDLE : GAP;
         GAP: begin
            if (!i_enable)                            state_next = IDLE;
            else if (tick_1ms && gap_cnt == GAP_LAST) state_next = START;
         end
         default: state_next = IDLE;
      endcase
      enter_start = (state_next == START) && (state != START);
   end

   // Counters, pending flags and published results
   always_ff @(posedge clk) begin
      if (rst) begin
         poll_cnt   <= '0;
         tmo_cnt    <= '0;
         gap_cnt    <= '0;
         retry_cnt  <= '0;
         force_pend <= 1'b0;
         first_pend <= 1'b1;
         o_humi_int <= '0;
         o_humi_dec <= '0;
         o_temp_int <= '0;
         o_temp_dec <= '0;
         o_valid    <= 1'b0;
         o_update   <= 1'b0;
         o_err      <= 1'b0;
         o_fail_cnt <= '0;
      end else begin
         o_update <= 1'b0;

         // Only first-attempt launches restart the poll period
         if (enter_start && retry_cnt == '0)
            poll_cnt <= '0;
         else if (tick_1ms && poll_cnt != POLL_LAST)
            poll_cnt <= poll_cnt + 1'b1;

         if (enter_start)  force_pend <= 1'b0;
         else if (i_force) force_pend <= 1'b1;

         if (enter_start) first_pend <= 1'b0;

         unique case (state)
            START: tmo_cnt <= '0;
            BUSY:  if (tick_1ms) tmo_cnt <= tmo_cnt + 1'b1;
            CHECK: begin
               if (chk_ok) begin
                  o_humi_int <= chk_humi_int;
                  o_humi_dec <= chk_humi_dec;
                  o_temp_int <= chk_temp_int;
                  o_temp_dec <= chk_temp_dec;
                  o_valid    <= 1'b1;
                  o_update   <= 1'b1;
                  o_err      <= 1'b0;
                  retry_cnt  <= '0;
               end
            end
            FAIL: begin
               if (o_fail_cnt != 8'hFF) o_fail_cnt <= o_fail_cnt + 1'b1;
               if (retry_cnt == RETRY_MAX) begin
                  o_err     <= 1'b1;
                  retry_cnt <= '0;
               end else begin
                  retry_cnt <= retry_cnt + 1'b1;
                  gap_cnt   <= '0;
               end
            end
            GAP: begin
               if (!i_enable)     retry_cnt <= '0;
               else if (tick_1ms) gap_cnt   <= gap_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// Directed bench for dht_poll_scheduler with a table of good frames plus
// hand-written multi-cycle sequences (retries, hang, force, reset).
module tb_dht_poll_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick_1ms;
   logic        i_enable;
   logic        i_force;
   logic        dht_start;
   logic [39:0] dht_data;
   logic        dht_done;
   logic        dht_tout;
   logic [7:0]  o_humi_int, o_humi_dec, o_temp_int, o_temp_dec;
   logic        o_valid, o_update, o_err, o_busy;
   logic [7:0]  o_fail_cnt;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   typedef struct {
      logic [39:0] data;
      logic [7:0]  hi, hd, ti, td;
   } vec_t;

   dht_poll_scheduler #(
      .DHT_OUT         (40),
      .POLL_MS         (20),
      .RETRY_GAP_MS    (5),
      .BUSY_TIMEOUT_MS (8),
      .MAX_RETRY       (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1ms   (tick_1ms),
      .i_enable   (i_enable),
      .i_force    (i_force),
      .dht_start  (dht_start),
      .dht_data   (dht_data),
      .dht_done   (dht_done),
      .dht_tout   (dht_tout),
      .o_humi_int (o_humi_int),
      .o_humi_dec (o_humi_dec),
      .o_temp_int (o_temp_int),
      .o_temp_dec (o_temp_dec),
      .o_valid    (o_valid),
      .o_update   (o_update),
      .o_err      (o_err),
      .o_fail_cnt (o_fail_cnt),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // 1 ms strobe every 10 clocks, changed on the falling edge
   initial begin
      tick_1ms = 1'b0;
      forever begin
         repeat (9) @(negedge clk);
         tick_1ms = 1'b1;
         @(negedge clk);
         tick_1ms = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_outputs(input string name, input logic [7:0] hi, input logic [7:0] hd,
                              input logic [7:0] ti, input logic [7:0] td);
      chk({name, "_humi_int"}, o_humi_int, hi);
      chk({name, "_humi_dec"}, o_humi_dec, hd);
      chk({name, "_temp_int"}, o_temp_int, ti);
      chk({name, "_temp_dec"}, o_temp_dec, td);
   endtask

   // Waits on falling edges for a start pulse; w = edges waited, -1 if none
   task automatic wait_start(input int limit, output int w);
      w = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (dht_start) begin
            w = i + 1;
            return;
         end
      end
   endtask

   task automatic force_read();
      @(negedge clk);
      i_force = 1'b1;
      @(negedge clk);
      i_force = 1'b0;
   endtask

   // Called right after a start was seen; finishes at the falling edge in CHECK
   task automatic respond(input logic [39:0] d, input logic tout);
      @(negedge clk);
      chk("start_one_cycle", dht_start, 1'b0);
      chk("busy_high", o_busy, 1'b1);
      dht_data = d;
      dht_done = 1'b1;
      dht_tout = tout;
      @(negedge clk);
      dht_done = 1'b0;
      dht_tout = 1'b0;
      chk("update_not_early", o_update, 1'b0);
   endtask

   initial begin
      vec_t tbl[5];
      int   w;
      int   t0;
      int   t;
      int   exp_fail;

      tbl[0] = '{40'h4101190A65, 8'h41, 8'h01, 8'h19, 8'h0A};
      tbl[1] = '{40'hFFFFFFFFFC, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      tbl[2] = '{40'h8080808000, 8'h80, 8'h80, 8'h80, 8'h80};
      tbl[3] = '{40'h1234567814, 8'h12, 8'h34, 8'h56, 8'h78};
      tbl[4] = '{40'h0000000000, 8'h00, 8'h00, 8'h00, 8'h00};

      rst = 1'b1; i_enable = 1'b0; i_force = 1'b0;
      dht_data = '0; dht_done = 1'b0; dht_tout = 1'b0;
      exp_fail = 0;
      repeat (5) @(negedge clk);

      // Reset state
      chk_outputs("reset", 8'h00, 8'h00, 8'h00, 8'h00);
      chk("reset_valid", o_valid, 1'b0);
      chk("reset_err", o_err, 1'b0);
      chk("reset_fail_cnt", o_fail_cnt, 8'h00);
      chk("reset_busy", o_busy, 1'b0);
      chk("reset_start", dht_start, 1'b0);
      rst = 1'b0;

      // First read right after enable
      @(negedge clk);
      chk("no_start_disabled", dht_start, 1'b0);
      i_enable = 1'b1;
      wait_start(3, w);
      chk("first_start_latency", w, 1);
      respond(40'h3700180554, 1'b0);
      @(negedge clk);
      chk("first_update", o_update, 1'b1);
      chk("first_valid", o_valid, 1'b1);
      chk_outputs("first", 8'h37, 8'h00, 8'h18, 8'h05);
      @(negedge clk);
      chk("update_one_cycle", o_update, 1'b0);
      chk("idle_busy", o_busy, 1'b0);

      // Bad checksum on every attempt: first try plus two retries
      force_read();
      wait_start(5, w);
      chk("bad_start0", (w > 0), 1'b1);
      for (int a = 0; a < 3; a++) begin
         respond(40'h3700180555, 1'b0);
         t0 = cyc;
         @(negedge clk);
         chk("bad_no_update", o_update, 1'b0);
         @(negedge clk);
         exp_fail++;
         chk("bad_fail_cnt", o_fail_cnt, 8'(exp_fail));
         if (a < 2) begin
            chk("bad_err_during_retry", o_err, 1'b0);
            wait_start(80, w);
            t = cyc - t0;
            chk("bad_retry_start", (w > 0), 1'b1);
            chk("bad_retry_gap", (t >= 40 && t <= 62), 1'b1);
         end
      end
      chk("bad_err", o_err, 1'b1);
      chk("bad_valid_kept", o_valid, 1'b1);
      chk_outputs("bad_kept", 8'h37, 8'h00, 8'h18, 8'h05);
      wait_start(30, w);
      chk("bad_no_more_retry", w, -1);

      // Table of good frames, each launched by i_force
      for (int i = 0; i < 5; i++) begin
         force_read();
         wait_start(5, w);
         chk("tbl_start", (w > 0), 1'b1);
         respond(tbl[i].data, 1'b0);
         @(negedge clk);
         chk("tbl_update", o_update, 1'b1);
         chk_outputs("tbl", tbl[i].hi, tbl[i].hd, tbl[i].ti, tbl[i].td);
         chk("tbl_err_cleared", o_err, 1'b0);
         chk("tbl_fail_cnt", o_fail_cnt, 8'(exp_fail));
      end

      // Controller hang: hang timer fails the attempt, retry follows
      force_read();
      wait_start(5, w);
      chk("hang_start", (w > 0), 1'b1);
      t0 = cyc;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (o_fail_cnt != 8'(exp_fail)) break;
      end
      t = cyc - t0;
      exp_fail++;
      chk("hang_fail_cnt", o_fail_cnt, 8'(exp_fail));
      chk("hang_time", (t >= 72 && t <= 86), 1'b1);
      wait_start(80, w);
      chk("hang_retry_start", (w > 0), 1'b1);
      respond(40'h3C05140257, 1'b0);
      @(negedge clk);
      chk("hang_recover_update", o_update, 1'b1);
      chk_outputs("hang_recover", 8'h3C, 8'h05, 8'h14, 8'h02);
      chk("hang_err", o_err, 1'b0);

      // done and tout together: done wins
      force_read();
      wait_start(5, w);
      chk("dt_start", (w > 0), 1'b1);
      respond(40'h2A03150749, 1'b1);
      @(negedge clk);
      chk("dt_update", o_update, 1'b1);
      chk_outputs("dt", 8'h2A, 8'h03, 8'h15, 8'h07);
      @(negedge clk);
      @(negedge clk);
      chk("dt_fail_cnt", o_fail_cnt, 8'(exp_fail));

      // Force during BUSY is served right after returning to IDLE
      force_read();
      wait_start(5, w);
      chk("fb_start", (w > 0), 1'b1);
      @(negedge clk);
      i_force = 1'b1;
      @(negedge clk);
      i_force = 1'b0;
      chk("fb_no_restart", dht_start, 1'b0);
      respond(40'h2B00160041, 1'b0);
      @(negedge clk);
      chk("fb_update", o_update, 1'b1);
      @(negedge clk);
      chk("fb_forced_start", dht_start, 1'b1);
      t0 = cyc;
      respond(40'h2B00160041, 1'b0);
      wait_start(260, w);
      t = cyc - t0;
      chk("poll_start", (w > 0), 1'b1);
      chk("poll_period", (t >= 175 && t <= 200), 1'b1);
      respond(40'h3700180554, 1'b0);
      @(negedge clk);
      chk("poll_update", o_update, 1'b1);

      // Reset in the middle of BUSY
      force_read();
      wait_start(5, w);
      chk("rst_start", (w > 0), 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_outputs("rst_busy", 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rst_busy_valid", o_valid, 1'b0);
      chk("rst_busy_fail_cnt", o_fail_cnt, 8'h00);
      chk("rst_busy_busy", o_busy, 1'b0);
      chk("rst_busy_start", dht_start, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_restart", dht_start, 1'b1);
      respond(40'h3700180554, 1'b0);
      @(negedge clk);
      chk("rst_recover_update", o_update, 1'b1);
      chk("rst_recover_valid", o_valid, 1'b1);
      chk_outputs("rst_recover", 8'h37, 8'h00, 8'h18, 8'h05);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
